cabac_ctx_init_ctrl: RTL and testbench

Context-initialisation sequencer placed directly downstream of the 16x64 CABAC init-value ROM. On `start` it sweeps all 64 ROM words and decodes each into a context state using the latched slice QP. It writes each {valMps, pStateIdx} result into the CABAC context memory and signals completion, so the arithmetic coder can begin the slice.

---
 rtl/cabac_ctx_pkg.sv | 17 +
 rtl/cabac_ctx_init_calc.sv | 24 ++
 rtl/cabac_ctx_init_ctrl.sv | 81 ++++++++
 tb/tb_cabac_ctx_init_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cabac_ctx_pkg.sv
// cabac_ctx_pkg: shared constants and FSM encoding for CABAC context initialisation.
package cabac_ctx_pkg;
    localparam int QP_MAX           = 51;
    localparam int PRE_MIN          = 1;
    localparam int PRE_MAX          = 126;
    localparam int MPS_THRESH       = 63;
    localparam int M_MSB            = 15;
    localparam int M_LSB            = 8;
    localparam int N_MSB            = 7;
    localparam int N_LSB            = 0;
    localparam int CTX_W_DATA_WIDTH = 7;
    localparam int FLUSH_LEN        = 2;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/cabac_ctx_init_calc.sv
// cabac_ctx_init_calc: maps one init-value (m, n) and clipped QP to {valMps, pStateIdx}.
module cabac_ctx_init_calc
    import cabac_ctx_pkg::*;
#(
    parameter int QP_WIDTH = 6
) (
    input  logic [7:0]                  m,
    input  logic [7:0]                  n,
    input  logic [QP_WIDTH-1:0]         qp,
    output logic [CTX_W_DATA_WIDTH-1:0] ctx
);
    localparam int PW = 8 + QP_WIDTH;
    localparam int TW = PW - 4;
    logic [PW-1:0] prod;
    logic [TW-1:0] t;
    logic [6:0]    pre;
    always_comb begin
        prod = {{QP_WIDTH{m[7]}}, m} * {8'd0, qp};
        // taking the upper bits of the two's-complement product is the floor shift
        t    = prod[PW-1:4] + {{(TW-8){1'b0}}, n};
        pre  = $signed(t) < PRE_MIN ? 7'(PRE_MIN) : $signed(t) > PRE_MAX ? 7'(PRE_MAX) : t[6:0];
        ctx  = pre > 7'(MPS_THRESH) ? {1'b1, pre[5:0]} : {1'b0, 6'(MPS_THRESH) - pre[5:0]};
    end
endmodule

// File: rtl/cabac_ctx_init_ctrl.sv
// cabac_ctx_init_ctrl: sweeps the init-value ROM and writes decoded context states.
module cabac_ctx_init_ctrl
    import cabac_ctx_pkg::*;
#(
    parameter int NUM_CTX   = 64,
    parameter int QP_WIDTH  = 6,
    parameter int ROM_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [QP_WIDTH-1:0]           qp,
    output logic                          busy,
    output logic                          done,
    output logic                          rom_r_en,
    output logic [$clog2(NUM_CTX)-1:0]    rom_r_addr,
    input  logic [ROM_WIDTH-1:0]          rom_r_data,
    output logic                          ctx_w_en,
    output logic [$clog2(NUM_CTX)-1:0]    ctx_w_addr,
    output logic [CTX_W_DATA_WIDTH-1:0]   ctx_w_data
);
    localparam int AW = $clog2(NUM_CTX);
    logic [1:0]                  state;
    logic [AW-1:0]               cnt;
    logic [QP_WIDTH-1:0]         qp_c;
    logic                        v1;
    logic [AW-1:0]               a1;
    logic [CTX_W_DATA_WIDTH-1:0] calc;
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign rom_r_en   = state == RUN;
    assign rom_r_addr = cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            qp_c  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    cnt   <= '0;
                    qp_c  <= qp > QP_WIDTH'(QP_MAX) ? QP_WIDTH'(QP_MAX) : qp;
                end
                RUN: begin
                    cnt   <= cnt == AW'(NUM_CTX - 1) ? '0 : cnt + 1'b1;
                    state <= cnt == AW'(NUM_CTX - 1) ? FLUSH : RUN;
                end
                FLUSH: begin
                    cnt   <= cnt == AW'(FLUSH_LEN - 1) ? '0 : cnt + 1'b1;
                    state <= cnt == AW'(FLUSH_LEN - 1) ? DONE : FLUSH;
                end
                default: state <= IDLE;
            endcase
        end
    end
    cabac_ctx_init_calc #(.QP_WIDTH(QP_WIDTH)) u_calc (
        .m   (rom_r_data[M_MSB:M_LSB]),
        .n   (rom_r_data[N_MSB:N_LSB]),
        .qp  (qp_c),
        .ctx (calc)
    );
    // v1/a1 ride alongside the ROM's registered data; only a valid word may update ctx_w_*
    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            a1         <= '0;
            ctx_w_en   <= 1'b0;
            ctx_w_addr <= '0;
            ctx_w_data <= '0;
        end else begin
            v1       <= rom_r_en;
            a1       <= rom_r_addr;
            ctx_w_en <= v1;
            if (v1) begin
                ctx_w_addr <= a1;
                ctx_w_data <= calc;
            end
        end
    end
endmodule

// File: tb/tb_cabac_ctx_init_ctrl.sv
// tb_cabac_ctx_init_ctrl: directed sweeps checked every cycle against a timeline model of the sequencer.
module tb_cabac_ctx_init_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  qp = '0;
    logic        busy, done, rom_r_en, ctx_w_en;
    logic [5:0]  rom_r_addr, ctx_w_addr;
    logic [15:0] rom_r_data;
    logic [6:0]  ctx_w_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] rom [64];

    int cyc = 0;
    int t0 = 0;
    bit active = 0;
    int qpl = 0;
    logic [6:0] last_data = '0;
    logic [5:0] last_addr = '0;
    int nwr = 0;
    int ndone = 0;
    logic [6:0] wr [64];

    cabac_ctx_init_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .qp(qp), .busy(busy), .done(done),
        .rom_r_en(rom_r_en), .rom_r_addr(rom_r_addr), .rom_r_data(rom_r_data),
        .ctx_w_en(ctx_w_en), .ctx_w_addr(ctx_w_addr), .ctx_w_data(ctx_w_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_r_data <= rom_r_en ? rom[rom_r_addr] : 'x;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_ctx(input logic [15:0] w, input int q);
        int m, n, qc, t, pre;
        m   = $signed(w[15:8]);
        n   = int'(w[7:0]);
        qc  = q > 51 ? 51 : q;
        t   = ((m * qc) >>> 4) + n;
        t   = t & 1023;
        t   = t >= 512 ? t - 1024 : t;
        pre = t < 1 ? 1 : (t > 126 ? 126 : t);
        return pre <= 63 ? {1'b0, 6'(63 - pre)} : {1'b1, 6'(pre - 64)};
    endfunction

    // Model: a sweep accepted at edge t0 is busy for 67 observations, writes on offsets 2..65, done at 66.
    always @(posedge clk) begin
        bit was_busy;
        was_busy = active && (cyc - t0) <= 66;
        cyc++;
        if (rst) begin
            active    = 0;
            last_data = '0;
            last_addr = '0;
        end else if (start && !was_busy) begin
            active = 1;
            t0     = cyc;
            qpl    = int'(qp);
        end
    end

    always @(negedge clk) begin
        int d;
        bit e_busy, e_en, e_done, e_ren;
        if (cyc > 0) begin
            d      = cyc - t0;
            e_busy = active && d <= 66;
            e_en   = active && d >= 2 && d <= 65;
            e_done = active && d == 66;
            e_ren  = active && d <= 63;
            if (e_en) begin
                last_addr = 6'(d - 2);
                last_data = ref_ctx(rom[d - 2], qpl);
            end
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("rom_r_en", 32'(rom_r_en), 32'(e_ren));
            if (e_ren) chk("rom_r_addr", 32'(rom_r_addr), 32'(d));
            chk("ctx_w_en", 32'(ctx_w_en), 32'(e_en));
            chk("ctx_w_addr", 32'(ctx_w_addr), 32'(last_addr));
            chk("ctx_w_data", 32'(ctx_w_data), 32'(last_data));
            if ($isunknown(ctx_w_en) || (ctx_w_en === 1'b1 && $isunknown(ctx_w_data))) begin
                checks++;
                errors++;
                $display("FAIL x_on_write at cycle %0d: en=%b data=%b", cyc, ctx_w_en, ctx_w_data);
            end
            if (ctx_w_en === 1'b1) begin
                nwr++;
                wr[ctx_w_addr] = ctx_w_data;
            end
            if (done === 1'b1) ndone++;
        end
    end

    task automatic pulse_start(input logic [5:0] q);
        @(negedge clk);
        start = 1'b1;
        qp    = q;
        @(negedge clk);
        start = 1'b0;
        qp    = ~q;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 200 && done !== 1'b1; k++) @(negedge clk);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, k);
        end
    endtask

    task automatic sweep(input logic [5:0] q);
        nwr   = 0;
        ndone = 0;
        pulse_start(q);
        wait_done();
        repeat (4) @(negedge clk);
        chk("sweep_writes", 32'(nwr), 32'd64);
        chk("sweep_done", 32'(ndone), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = {8'(i * 37 - 100), 8'(i * 53 + 11)};
        rom[0]  = 16'hfb40;
        rom[2]  = 16'h0040;
        rom[26] = 16'h1908;
        rom[55] = 16'hfb20;
        rom[57] = 16'h0f00;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_w_en", 32'(ctx_w_en), 32'd0);
        chk("reset_w_data", 32'(ctx_w_data), 32'd0);
        chk("reset_r_addr", 32'(rom_r_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        sweep(6'd26);
        chk("qp26_addr0", 32'(wr[0]), 32'h08);
        chk("qp26_addr2", 32'(wr[2]), 32'h40);
        chk("qp26_addr26", 32'(wr[26]), 32'h0f);

        sweep(6'd63);
        chk("qp63_addr26", 32'(wr[26]), 32'h57);
        chk("qp63_addr55", 32'(wr[55]), 32'h2f);

        sweep(6'd0);
        chk("qp0_addr57", 32'(wr[57]), 32'h3e);
        chk("qp0_addr0", 32'(wr[0]), 32'h40);

        // start while busy, including in the DONE cycle
        nwr   = 0;
        ndone = 0;
        pulse_start(6'd26);
        repeat (8) @(negedge clk);
        start = 1'b1;
        qp    = 6'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (80) @(negedge clk);
        chk("busy_start_writes", 32'(nwr), 32'd64);
        chk("busy_start_done", 32'(ndone), 32'd1);
        chk("busy_start_addr26", 32'(wr[26]), 32'h0f);

        // reset mid-sweep
        nwr   = 0;
        ndone = 0;
        pulse_start(6'd26);
        repeat (28) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_w_en", 32'(ctx_w_en), 32'd0);
        nwr = 0;
        repeat (80) @(negedge clk);
        chk("midrst_no_writes", 32'(nwr), 32'd0);
        chk("midrst_no_done", 32'(ndone), 32'd0);
        sweep(6'd51);
        chk("post_rst_addr26", 32'(wr[26]), 32'h57);

        // start coinciding with reset
        nwr   = 0;
        ndone = 0;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'd0);
        chk("rst_start_writes", 32'(nwr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
